// File: rtl/if_stage_pkg.sv
// Shared processor definitions for the fetch stage: state encoding, NOP word and
// the PC legality helper.
package if_stage_pkg;

   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StRun   = 2'd1,
      StFault = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // A PC is fetchable when word-aligned and inside the instruction memory.
   function automatic logic pc_legal(input logic [31:0] pc, input int unsigned words);
      return (pc[1:0] == 2'b00) && (pc < (words << 2));
   endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, one-entry output pipeline register with
// valid/ready handshake, redirect handling and a sticky fetch fault.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fetch_fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         out_valid_q, out_valid_d;
   logic [31:0]  out_pc_q, out_pc_d;
   logic [31:0]  out_instr_q, out_instr_d;
   logic         fault_q, fault_d;
   logic [31:0]  pc_inc;

   assign pc_inc = pc_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      fault_d     = fault_q;

      unique case (state_q)
         StBoot: begin
            out_valid_d = 1'b0;
            state_d     = StRun;
         end
         StRun: begin
            // Redirect wins; any transfer seen this cycle has already completed.
            if (redirect_valid) begin
               pc_d        = redirect_pc;
               out_valid_d = 1'b0;
               if (!pc_legal(redirect_pc, IMEM_WORDS)) begin
                  state_d = StFault;
                  fault_d = 1'b1;
               end
            end else if (!out_valid_q || out_ready) begin
               out_instr_d = imem_instr;
               out_pc_d    = pc_q;
               out_valid_d = 1'b1;
               pc_d        = pc_inc;
               if (!pc_legal(pc_inc, IMEM_WORDS)) begin
                  state_d = StFault;
                  fault_d = 1'b1;
               end
            end
         end
         StFault: begin
            out_valid_d = 1'b0;
         end
         default: begin
            state_d     = StFault;
            out_valid_d = 1'b0;
            fault_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StBoot;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_pc_q    <= 32'h0000_0000;
         out_instr_q <= NOP_INSTR;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         fault_q     <= fault_d;
      end
   end

   assign imem_addr   = pc_q;
   assign out_valid   = out_valid_q;
   assign out_pc      = out_pc_q;
   assign out_instr   = out_instr_q;
   assign fetch_fault = fault_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 1024: instruction memory depth in 32-bit words; legal PC range is 0 .. IMEM_WORDS*4-4.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_addr  output  32: byte address to instruction memory; memory read is combinational and word-aligned.
REQ-006 SHALL have port imem_instr  input  32: instruction word returned for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1: branch/jump taken; replaces the PC.
REQ-008 SHALL have port redirect_pc  input  32: redirect target byte address.
REQ-009 SHALL have port out_valid  output  1: out_pc/out_instr hold a valid fetched instruction.
REQ-010 SHALL have port out_ready  input  1: decode accepts; transfer occurs when out_valid && out_ready.
REQ-011 SHALL have port out_pc  output  32: byte address of out_instr.
REQ-012 SHALL have port out_instr  output  32: fetched instruction.
REQ-013 SHALL have port fetch_fault  output  1: sticky; PC misaligned or outside legal range.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, FAULT; BOOT -> RUN on the first clock edge after rst_n deasserts; RUN -> FAULT per REQ-020; FAULT is left only by reset.
REQ-015 SHALL drive imem_addr = pc combinationally in every state; pc is a 32-bit register.
REQ-016 In RUN, SHALL capture when (!out_valid || out_ready) and no redirect: out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc + 4 (mod 2^32); fetch-to-output latency is 1 cycle.
REQ-017 In RUN with out_valid && !out_ready and no redirect, SHALL hold pc, out_pc, out_instr and out_valid unchanged (no drop, no duplicate).
REQ-018 SHALL give redirect_valid priority over capture and stall: pc <= redirect_pc, out_valid <= 0 on that edge; first redirected instruction appears with out_valid = 1 one cycle later.
REQ-019 When redirect_valid coincides with out_valid && out_ready, the transfer in that cycle SHALL count as completed; the entry is then flushed.
REQ-020 SHALL enter FAULT and set fetch_fault = 1 on the edge where the next pc would be misaligned (bits [1:0] != 0) or >= IMEM_WORDS*4, including an accepted redirect target and sequential pc + 4 past the end; pc takes the offending value.
REQ-021 In FAULT, SHALL hold out_valid = 0, ignore redirect_valid and out_ready, and hold pc.
REQ-022 In BOOT, SHALL hold out_valid = 0 and ignore redirect_valid.

Reset
REQ-023 On rst_n low, SHALL asynchronously set state = BOOT, pc = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 32'h0000_0013 (NOP), fetch_fault = 0.
REQ-024 SHALL discard any in-flight instruction or pending redirect when reset asserts mid-operation; no partial update survives.

Structure
REQ-025 SHALL take the FSM state enum, NOP_INSTR (32'h0000_0013) and the RESET_PC default from the shared processor package.
REQ-026 SHALL be a single module with no sub-modules; the PC register and the output pipeline register reside in if_stage.

Verification
REQ-027 Reset, then out_ready = 1 with memory holding 00500093, 00600113, 002081b3, 403101b3 -> out_pc 0,4,8,12 on consecutive cycles with those instructions, out_valid high from the second edge after reset release.
REQ-028 out_ready = 0 for 3 cycles while out_pc = 4 -> out_pc = 4, out_instr = 00600113 stable; on release, next output is pc 8 (no skip, no repeat).
REQ-029 redirect_valid = 1, redirect_pc = 0 while out_pc = 8 and out_ready = 1 -> out_valid = 0 next cycle, then out_pc = 0, out_instr = 00500093.
REQ-030 redirect_pc = 32'h0000_0006 -> fetch_fault = 1 next edge, out_valid = 0 thereafter; later redirect to 0 ignored until rst_n pulse.
REQ-031 Sequential fetch from pc = 4092 -> instruction at 4092 delivered, then fetch_fault = 1 with pc = 4096.
REQ-032 rst_n asserted mid-stall (out_valid = 1, out_ready = 0) -> immediately out_valid = 0, out_instr = 00000013, pc = RESET_PC.
